// File: rtl/flag_pkg.sv
// Shared types and constants for the NZCV condition-flag producer.
// Bit positions follow the {N,Z,C,V} order of the Flags bus.
package flag_pkg;

    typedef enum logic [1:0] {
        ADD   = 2'b00,
        SUB   = 2'b01,
        LOGIC = 2'b10,
        RSVD  = 2'b11
    } alu_kind_t;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    // Overlay the selected flag groups of cand onto cur; unselected groups keep cur.
    function automatic logic [3:0] merge_groups(input logic [3:0] cur,
                                                input logic [3:0] cand,
                                                input logic [1:0] flagw);
        logic [3:0] merged;
        merged = cur;
        if (flagw[FLAGW_NZ]) begin
            merged[N_IDX] = cand[N_IDX];
            merged[Z_IDX] = cand[Z_IDX];
        end
        if (flagw[FLAGW_CV]) begin
            merged[C_IDX] = cand[C_IDX];
            merged[V_IDX] = cand[V_IDX];
        end
        return merged;
    endfunction

endpackage

// File: rtl/flag_compute.sv
// Combinational NZCV candidate generation from execute-stage operands and result.
// The reserved ALU kind produces a don't-care candidate; the writer suppresses it.
module flag_compute
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       AluKind,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] Result,
    input  logic             ShCarry,
    input  logic             cur_v,
    output logic [3:0]       cand
);

    alu_kind_t        kind;
    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;

    assign kind = alu_kind_t'(AluKind);

    // Subtraction reuses the adder as A + ~B + 1, so carry-out means "no borrow".
    always_comb begin
        b_op = SrcB;
        cin  = 1'b0;
        if (kind == SUB) begin
            b_op = ~SrcB;
            cin  = 1'b1;
        end
        sum = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    end

    // With B already inverted for SUB, one overflow rule serves both ADD and SUB.
    always_comb begin
        cand        = 4'b0000;
        cand[V_IDX] = cur_v;
        case (kind)
            ADD, SUB: begin
                cand[N_IDX] = sum[WIDTH-1];
                cand[Z_IDX] = (sum[WIDTH-1:0] == '0);
                cand[C_IDX] = sum[WIDTH];
                cand[V_IDX] = (SrcA[WIDTH-1] == b_op[WIDTH-1]) &&
                              (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            LOGIC: begin
                cand[N_IDX] = Result[WIDTH-1];
                cand[Z_IDX] = (Result == '0);
                cand[C_IDX] = ShCarry;
                cand[V_IDX] = cur_v;
            end
            default: begin
                cand[V_IDX] = cur_v;
            end
        endcase
    end

endmodule

// File: rtl/flag_writer.sv
// Architectural NZCV flags register with same-cycle bypass and a one-deep
// shadow copy used to save/restore flags across exception entry and return.
module flag_writer
    import flag_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Valid,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             CondEx,
    input  logic [1:0]       FlagW,
    input  logic [1:0]       AluKind,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] Result,
    input  logic             ShCarry,
    input  logic             SaveFlags,
    input  logic             RestoreFlags,
    output logic [3:0]       Flags,
    output logic [3:0]       FlagsBypass,
    output logic             SavedValid
);

    logic [3:0] flags_q;
    logic [3:0] shadow_q;
    logic       saved_q;
    logic [3:0] cand;
    logic [3:0] write_val;
    logic       we;
    logic       save_go;
    logic       restore_go;

    flag_compute #(
        .WIDTH(WIDTH)
    ) u_compute (
        .AluKind (AluKind),
        .SrcA    (SrcA),
        .SrcB    (SrcB),
        .Result  (Result),
        .ShCarry (ShCarry),
        .cur_v   (flags_q[V_IDX]),
        .cand    (cand)
    );

    // Save and restore are exception-control driven, so Flush does not gate them.
    assign we         = Valid && CondEx && !Stall && !Flush &&
                        (alu_kind_t'(AluKind) != RSVD);
    assign save_go    = SaveFlags && !Stall;
    assign restore_go = RestoreFlags && !Stall && saved_q;
    assign write_val  = merge_groups(flags_q, cand, FlagW);

    // Restore beats a concurrent write; with nothing written the bypass mirrors Flags.
    always_comb begin
        FlagsBypass = flags_q;
        if (restore_go) begin
            FlagsBypass = shadow_q;
        end else if (we) begin
            FlagsBypass = write_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= FLAGS_RST;
            shadow_q <= FLAGS_RST;
            saved_q  <= 1'b0;
        end else begin
            flags_q <= FlagsBypass;
            if (save_go) begin
                shadow_q <= flags_q;
            end
            if (save_go) begin
                saved_q <= 1'b1;
            end else if (restore_go) begin
                saved_q <= 1'b0;
            end
        end
    end

    assign Flags      = flags_q;
    assign SavedValid = saved_q;

endmodule

// File: tb/tb_flag_writer.sv
// Directed self-checking bench for flag_writer with hand-computed NZCV values.
module tb_flag_writer;

    localparam logic [1:0] K_ADD   = 2'b00;
    localparam logic [1:0] K_SUB   = 2'b01;
    localparam logic [1:0] K_LOGIC = 2'b10;
    localparam logic [1:0] K_RSVD  = 2'b11;

    logic        clk;
    logic        reset_n;
    logic        Valid;
    logic        Stall;
    logic        Flush;
    logic        CondEx;
    logic [1:0]  FlagW;
    logic [1:0]  AluKind;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] Result;
    logic        ShCarry;
    logic        SaveFlags;
    logic        RestoreFlags;
    logic [3:0]  Flags;
    logic [3:0]  FlagsBypass;
    logic        SavedValid;

    int testsRun  = 0;
    int failCount = 0;

    flag_writer #(
        .WIDTH     (32),
        .FLAGS_RST (4'b0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Valid        (Valid),
        .Stall        (Stall),
        .Flush        (Flush),
        .CondEx       (CondEx),
        .FlagW        (FlagW),
        .AluKind      (AluKind),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .Result       (Result),
        .ShCarry      (ShCarry),
        .SaveFlags    (SaveFlags),
        .RestoreFlags (RestoreFlags),
        .Flags        (Flags),
        .FlagsBypass  (FlagsBypass),
        .SavedValid   (SavedValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge, well clear of the next one.
    task automatic applyStimulus(input logic [1:0] kind, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] res,
                                 input logic shc, input logic [1:0] fw,
                                 input logic valid, input logic condex,
                                 input logic stall, input logic flush,
                                 input logic save, input logic restore);
        AluKind      = kind;
        SrcA         = a;
        SrcB         = b;
        Result       = res;
        ShCarry      = shc;
        FlagW        = fw;
        Valid        = valid;
        CondEx       = condex;
        Stall        = stall;
        Flush        = flush;
        SaveFlags    = save;
        RestoreFlags = restore;
    endtask

    task automatic stepCheck(input string tag, input logic [3:0] expByp,
                             input logic [3:0] expFlags);
        #1;
        checkOutput({tag, "_byp"}, {28'd0, FlagsBypass}, {28'd0, expByp});
        @(posedge clk);
        #1;
        checkOutput({tag, "_flags"}, {28'd0, Flags}, {28'd0, expFlags});
    endtask

    task automatic idle();
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #1;
        checkOutput("rst_flags", {28'd0, Flags}, 32'h0);
        checkOutput("rst_saved", {31'd0, SavedValid}, 32'h0);
        checkOutput("rst_byp", {28'd0, FlagsBypass}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("sub55", 4'b0110, 4'b0110);
        applyStimulus(K_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("add_ovf", 4'b1001, 4'b1001);
        applyStimulus(K_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("add_carry", 4'b0110, 4'b0110);
        applyStimulus(K_ADD, 32'h80000000, 32'h80000000, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("add_negneg", 4'b0111, 4'b0111);
        applyStimulus(K_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("sub_nz_only", 4'b1011, 4'b1011);
        applyStimulus(K_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("condex0", 4'b1011, 4'b1011);
        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCheck("flush", 4'b1011, 4'b1011);
        applyStimulus(K_RSVD, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("rsvd", 4'b1011, 4'b1011);
        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("flagw00", 4'b1011, 4'b1011);
        applyStimulus(K_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("add_nz_only", 4'b0011, 4'b0011);
        applyStimulus(K_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("sub_cv_only", 4'b0001, 4'b0001);
        applyStimulus(K_LOGIC, 32'd9, 32'd9, 32'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("logic_vkeep", 4'b0111, 4'b0111);
        applyStimulus(K_LOGIC, 32'd9, 32'd9, 32'h80000000, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCheck("stall", 4'b0111, 4'b0111);

        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("pre_save", 4'b0110, 4'b0110);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCheck("save", 4'b0110, 4'b0110);
        checkOutput("save_valid", {31'd0, SavedValid}, 32'h1);
        applyStimulus(K_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("post_save_wr", 4'b1001, 4'b1001);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("restore", 4'b0110, 4'b0110);
        checkOutput("restore_valid", {31'd0, SavedValid}, 32'h0);
        applyStimulus(K_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("rewrite", 4'b1001, 4'b1001);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("restore_empty", 4'b1001, 4'b1001);
        checkOutput("restore_empty_valid", {31'd0, SavedValid}, 32'h0);

        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCheck("save_and_wr", 4'b0110, 4'b0110);
        checkOutput("save_and_wr_valid", {31'd0, SavedValid}, 32'h1);
        applyStimulus(K_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("restore_and_wr", 4'b1001, 4'b1001);
        checkOutput("restore_and_wr_valid", {31'd0, SavedValid}, 32'h0);

        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCheck("save2", 4'b1001, 4'b1001);
        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("wr2", 4'b0110, 4'b0110);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        stepCheck("swap", 4'b1001, 4'b1001);
        checkOutput("swap_valid", {31'd0, SavedValid}, 32'h1);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("swap_restore", 4'b0110, 4'b0110);
        checkOutput("swap_restore_valid", {31'd0, SavedValid}, 32'h0);

        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        stepCheck("save3", 4'b0110, 4'b0110);
        applyStimulus(K_ADD, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("wr3", 4'b1001, 4'b1001);
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCheck("stall_restore", 4'b1001, 4'b1001);
        checkOutput("stall_restore_valid", {31'd0, SavedValid}, 32'h1);

        // Reset asserted mid-cycle must clear state without waiting for an edge.
        applyStimulus(K_SUB, 32'd3, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("pre_reset_byp", {28'd0, FlagsBypass}, 32'h8);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_flags", {28'd0, Flags}, 32'h0);
        checkOutput("async_rst_valid", {31'd0, SavedValid}, 32'h0);
        idle();
        #1;
        checkOutput("async_rst_byp", {28'd0, FlagsBypass}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(K_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCheck("post_rst_restore", 4'b0000, 4'b0000);
        applyStimulus(K_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCheck("post_rst_sub", 4'b0110, 4'b0110);

        idle();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
